// File: rtl/bus_pkg.sv
// Shared encodings for the memory-mapped bus initiator and its lane logic.
// Holds the size/error codes, the FSM state type and the alignment rule.
package bus_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_ALIGN   = 2'b01;
   localparam logic [1:0] ERR_DECODE  = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUS  = 2'b01,
      RESP = 2'b10
   } state_t;

   // Size 11 has no legal encoding, so it is always reported as misaligned.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addr_lo[0];
         SZ_WORD: bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/bus_lane.sv
// Byte-lane steering for the bus: store strobes/replication and load extraction/extension.
// Purely combinational so other bus masters can reuse it.
module bus_lane
   import bus_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        we,
   input  logic        zext,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata_rep,
   output logic [31:0] load_data
);

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [3:0]  strb;

   assign rd_byte = rdata[{addr_lo, 3'b000} +: 8];
   assign rd_half = rdata[{addr_lo[1], 4'b0000} +: 16];

   always_comb begin
      strb      = 4'b1111;
      wdata_rep = wdata;
      load_data = rdata;
      case (size)
         SZ_BYTE: begin
            strb      = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
            load_data = {{24{~zext & rd_byte[7]}}, rd_byte};
         end
         SZ_HALF: begin
            strb      = 4'b0011 << addr_lo;
            wdata_rep = {2{wdata[15:0]}};
            load_data = {{16{~zext & rd_half[15]}}, rd_half};
         end
         default: ;
      endcase
   end

   assign wstrb = we ? strb : 4'b0000;

endmodule

// File: rtl/bus_initiator.sv
// Initiator end of the memory-mapped bus: takes one core load/store at a time, runs a
// single bus cycle with decode and timeout checking, and returns a one-cycle response.
module bus_initiator
   import bus_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned TW      = $clog2(TIMEOUT) + 1
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [1:0]  resp_err,
   output logic        bus_en,
   output logic [31:0] bus_addr,
   output logic        bus_we,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_wdata,
   input  logic        bus_claim,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   state_t        state_q, state_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic [31:0]   addr_q;
   logic          we_q;
   logic [1:0]    size_q;
   logic          zext_q;
   logic [31:0]   wdata_q;
   logic [1:0]    err_q, err_d;
   logic [31:0]   rdata_q, rdata_d;

   logic          accept;
   logic [3:0]    lane_wstrb;
   logic [31:0]   lane_wdata;
   logic [31:0]   lane_load;

   assign accept = (state_q == IDLE) && req_valid;

   bus_lane u_lane (
      .addr_lo   (addr_q[1:0]),
      .size      (size_q),
      .we        (we_q),
      .zext      (zext_q),
      .wdata     (wdata_q),
      .rdata     (bus_rdata),
      .wstrb     (lane_wstrb),
      .wdata_rep (lane_wdata),
      .load_data (lane_load)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= ERR_OK;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         addr_q  <= '0;
         we_q    <= 1'b0;
         size_q  <= SZ_BYTE;
         zext_q  <= 1'b0;
         wdata_q <= '0;
      end else if (accept) begin
         addr_q  <= req_addr;
         we_q    <= req_we;
         size_q  <= req_size;
         zext_q  <= req_unsigned;
         wdata_q <= req_wdata;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (req_valid) begin
               rdata_d = '0;
               if (misaligned(req_size, req_addr[1:0])) begin
                  err_d   = ERR_ALIGN;
                  state_d = RESP;
               end else begin
                  state_d = BUS;
               end
            end
         end
         BUS: begin
            cnt_d = cnt_q + 1'b1;
            // Claim is only meaningful once the decoders have seen the address for a cycle.
            if ((cnt_q == '0) && !bus_claim) begin
               err_d   = ERR_DECODE;
               rdata_d = '0;
               state_d = RESP;
            end else if (bus_ack) begin
               err_d   = ERR_OK;
               rdata_d = we_q ? 32'h0 : lane_load;
               state_d = RESP;
            end else if (cnt_d == TW'(TIMEOUT)) begin
               err_d   = ERR_TIMEOUT;
               rdata_d = '0;
               state_d = RESP;
            end
         end
         RESP: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Bus and response outputs decode straight from state so reset clears them at once.
   assign req_ready  = (state_q == IDLE);
   assign bus_en     = (state_q == BUS);
   assign bus_addr   = bus_en ? {addr_q[31:2], 2'b00} : 32'h0;
   assign bus_we     = bus_en & we_q;
   assign bus_wstrb  = bus_en ? lane_wstrb : 4'b0000;
   assign bus_wdata  = bus_en ? lane_wdata : 32'h0;
   assign resp_valid = (state_q == RESP);
   assign resp_err   = resp_valid ? err_q : ERR_OK;
   assign resp_rdata = resp_valid ? rdata_q : 32'h0;

endmodule

// File: tb/tb_bus_initiator.sv
// Self-checking bench for bus_initiator: directed vector table, reset corner case and
// randomized transactions checked against a behavioural model of the access rules.
module tb_bus_initiator;

   localparam int unsigned TIMEOUT = 16;
   localparam int          NCYC    = TIMEOUT + 3;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;
   logic        bus_en, bus_we, bus_claim, bus_ack;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_wstrb;

   always #5 clk = ~clk;

   bus_initiator #(.TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .bus_en       (bus_en),
      .bus_addr     (bus_addr),
      .bus_we       (bus_we),
      .bus_wstrb    (bus_wstrb),
      .bus_wdata    (bus_wdata),
      .bus_claim    (bus_claim),
      .bus_ack      (bus_ack),
      .bus_rdata    (bus_rdata)
   );

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] wdata;
      logic        claim;
      int          ack_cyc;   // cycle after accept carrying bus_ack; 0 = never
      logic [31:0] rdata;
   } txn_t;

   typedef struct {
      logic [1:0]  err;
      logic [31:0] rdata;
      int          resp_cyc;
      int          nbus;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic [31:0] baddr;
   } exp_t;

   typedef struct {
      txn_t t;
      exp_t e;
   } vec_t;

   typedef struct {
      logic [1:0]  err;
      logic [31:0] rdata;
      int          resp_cyc;
      int          nresp;
      int          nbus;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic [31:0] baddr;
      logic        we;
      logic        stable;
      logic        ready_end;
   } obs_t;

   int passed = 0;
   int total  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference model: derived from byte counts and shifts, not lane muxes.
   function automatic exp_t model(input txn_t t);
      exp_t        e;
      int          nb;
      int          off;
      logic [31:0] mask;
      logic [31:0] v;
      e    = '{err: 2'b00, rdata: 32'h0, resp_cyc: 0, nbus: 0, wstrb: 4'h0, wdata: 32'h0,
               baddr: 32'h0};
      nb   = (t.size == 2'd0) ? 1 : (t.size == 2'd1) ? 2 : 4;
      off  = int'(t.addr[1:0]);
      e.baddr = t.addr & ~32'h3;
      e.wstrb = t.we ? 4'(((1 << nb) - 1) << off) : 4'h0;
      e.wdata = (nb == 1) ? (t.wdata & 32'hFF) * 32'h01010101 :
                (nb == 2) ? (t.wdata & 32'hFFFF) * 32'h00010001 : t.wdata;
      if (t.size == 2'b11 || (off % nb) != 0) begin
         e.err = 2'd1; e.resp_cyc = 1; e.nbus = 0;
      end else if (!t.claim) begin
         e.err = 2'd2; e.resp_cyc = 2; e.nbus = 1;
      end else if (t.ack_cyc >= 1 && t.ack_cyc <= int'(TIMEOUT)) begin
         e.err = 2'd0; e.resp_cyc = t.ack_cyc + 1; e.nbus = t.ack_cyc;
         if (!t.we) begin
            mask = (nb == 4) ? 32'hFFFFFFFF : 32'((1 << (8 * nb)) - 1);
            v    = (t.rdata >> (8 * off)) & mask;
            if (!t.uns && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
            e.rdata = v;
         end
      end else begin
         e.err = 2'd3; e.resp_cyc = int'(TIMEOUT) + 1; e.nbus = int'(TIMEOUT);
      end
      return e;
   endfunction

   // Issue one request and act as the bus target; cycle c=1 is the cycle after acceptance.
   task automatic run_txn(input txn_t t, output obs_t o);
      o = '{err: 2'b00, rdata: 32'h0, resp_cyc: 0, nresp: 0, nbus: 0, wstrb: 4'h0,
            wdata: 32'h0, baddr: 32'h0, we: 1'b0, stable: 1'b1, ready_end: 1'b0};
      @(negedge clk);
      req_valid    = 1'b1;
      req_addr     = t.addr;
      req_we       = t.we;
      req_size     = t.size;
      req_unsigned = t.uns;
      req_wdata    = t.wdata;
      bus_claim    = t.claim;
      bus_ack      = 1'b0;
      for (int c = 1; c <= NCYC; c++) begin
         @(negedge clk);
         if (c == 1) begin
            req_valid    = 1'b0;
            req_addr     = $urandom;
            req_we       = 1'($urandom);
            req_size     = 2'($urandom);
            req_unsigned = 1'($urandom);
            req_wdata    = $urandom;
         end
         if (resp_valid) begin
            o.nresp++;
            if (o.nresp == 1) begin
               o.resp_cyc = c;
               o.err      = resp_err;
               o.rdata    = resp_rdata;
            end
         end
         if (bus_en) begin
            o.nbus++;
            if (o.nbus == 1) begin
               o.baddr = bus_addr;
               o.we    = bus_we;
               o.wstrb = bus_wstrb;
               o.wdata = bus_wdata;
            end else if (bus_addr !== o.baddr || bus_we !== o.we || bus_wstrb !== o.wstrb ||
                         bus_wdata !== o.wdata) begin
               o.stable = 1'b0;
            end
         end
         bus_claim = t.claim;
         bus_ack   = (c == t.ack_cyc);
         bus_rdata = bus_ack ? t.rdata : $urandom;
      end
      bus_ack     = 1'b0;
      o.ready_end = req_ready;
   endtask

   task automatic compare(input string tag, input txn_t t, input exp_t e, input obs_t o);
      check($sformatf("%s resp_cycle", tag), o.resp_cyc, e.resp_cyc);
      check($sformatf("%s resp_pulses", tag), o.nresp, 1);
      check($sformatf("%s resp_err", tag), {30'h0, o.err}, {30'h0, e.err});
      check($sformatf("%s resp_rdata", tag), o.rdata, e.rdata);
      check($sformatf("%s bus_en_cycles", tag), o.nbus, e.nbus);
      check($sformatf("%s req_ready_after", tag), {31'h0, o.ready_end}, 32'h1);
      if (e.nbus > 0) begin
         check($sformatf("%s bus_addr", tag), o.baddr, e.baddr);
         check($sformatf("%s bus_we", tag), {31'h0, o.we}, {31'h0, t.we});
         check($sformatf("%s bus_wstrb", tag), {28'h0, o.wstrb}, {28'h0, e.wstrb});
         check($sformatf("%s bus_stable", tag), {31'h0, o.stable}, 32'h1);
         if (t.we) check($sformatf("%s bus_wdata", tag), o.wdata, e.wdata);
      end
   endtask

   vec_t vecs[11];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      txn_t t;
      exp_t e;
      obs_t o;
      int   pulses;

      // {addr, we, size, uns, wdata, claim, ack_cyc, rdata},
      // {err, rdata, resp_cyc, nbus, wstrb, wdata, baddr}
      vecs[0]  = '{'{32'h00001004, 1'b0, 2'b10, 1'b0, 32'h0, 1'b1, 1, 32'hDEADBEEF},
                   '{2'd0, 32'hDEADBEEF, 2, 1, 4'h0, 32'h0, 32'h00001004}};
      vecs[1]  = '{'{32'h00001003, 1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 1, 32'h80FFFFFF},
                   '{2'd0, 32'hFFFFFF80, 2, 1, 4'h0, 32'h0, 32'h00001000}};
      vecs[2]  = '{'{32'h00001003, 1'b0, 2'b00, 1'b1, 32'h0, 1'b1, 1, 32'h80FFFFFF},
                   '{2'd0, 32'h00000080, 2, 1, 4'h0, 32'h0, 32'h00001000}};
      vecs[3]  = '{'{32'h00002002, 1'b1, 2'b01, 1'b0, 32'h0000ABCD, 1'b1, 2, 32'h0},
                   '{2'd0, 32'h0, 3, 2, 4'hC, 32'hABCDABCD, 32'h00002000}};
      vecs[4]  = '{'{32'h00000006, 1'b0, 2'b10, 1'b0, 32'h0, 1'b1, 1, 32'h0},
                   '{2'd1, 32'h0, 1, 0, 4'h0, 32'h0, 32'h0}};
      vecs[5]  = '{'{32'h00000030, 1'b0, 2'b10, 1'b0, 32'h0, 1'b0, 1, 32'h11111111},
                   '{2'd2, 32'h0, 2, 1, 4'h0, 32'h0, 32'h00000030}};
      vecs[6]  = '{'{32'h00000020, 1'b0, 2'b10, 1'b0, 32'h0, 1'b1, 0, 32'h0},
                   '{2'd3, 32'h0, 17, 16, 4'h0, 32'h0, 32'h00000020}};
      vecs[7]  = '{'{32'h00000010, 1'b0, 2'b10, 1'b0, 32'h0, 1'b1, 16, 32'h12345678},
                   '{2'd0, 32'h12345678, 17, 16, 4'h0, 32'h0, 32'h00000010}};
      vecs[8]  = '{'{32'h00000040, 1'b0, 2'b11, 1'b0, 32'h0, 1'b1, 1, 32'h0},
                   '{2'd1, 32'h0, 1, 0, 4'h0, 32'h0, 32'h0}};
      vecs[9]  = '{'{32'h00003001, 1'b1, 2'b00, 1'b0, 32'h1234565A, 1'b1, 3, 32'h0},
                   '{2'd0, 32'h0, 4, 3, 4'h2, 32'h5A5A5A5A, 32'h00003000}};
      vecs[10] = '{'{32'h00004002, 1'b0, 2'b01, 1'b0, 32'h0, 1'b1, 1, 32'h80011234},
                   '{2'd0, 32'hFFFF8001, 2, 1, 4'h0, 32'h0, 32'h00004000}};

      n_rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_wdata = '0; bus_claim = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
      #12;
      check("reset req_ready", {31'h0, req_ready}, 32'h1);
      check("reset bus_en", {31'h0, bus_en}, 32'h0);
      check("reset resp_valid", {31'h0, resp_valid}, 32'h0);
      check("reset bus_wstrb", {28'h0, bus_wstrb}, 32'h0);
      @(negedge clk);
      n_rst = 1'b1;

      for (int i = 0; i < 11; i++) begin
         run_txn(vecs[i].t, o);
         compare($sformatf("vec%0d", i), vecs[i].t, vecs[i].e, o);
      end

      // Reset in the middle of a bus cycle: bus_en must drop without waiting for a clock.
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h00000050; req_we = 1'b0; req_size = 2'b10;
      bus_claim = 1'b1; bus_ack = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("midbus bus_en", {31'h0, bus_en}, 32'h1);
      @(posedge clk);
      #2 n_rst = 1'b0;
      #1;
      check("async reset bus_en", {31'h0, bus_en}, 32'h0);
      check("async reset req_ready", {31'h0, req_ready}, 32'h1);
      pulses = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (resp_valid) pulses++;
      end
      n_rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (resp_valid) pulses++;
      end
      check("reset no resp_valid", pulses, 0);
      check("after reset req_ready", {31'h0, req_ready}, 32'h1);
      run_txn(vecs[0].t, o);
      compare("post_reset", vecs[0].t, vecs[0].e, o);

      for (int i = 0; i < 150; i++) begin
         t.addr    = $urandom;
         t.we      = 1'($urandom);
         t.size    = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         t.uns     = 1'($urandom);
         t.wdata   = $urandom;
         t.claim   = ($urandom_range(0, 9) != 0);
         t.ack_cyc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TIMEOUT + 1))
                                                 : int'($urandom_range(1, 3));
         t.rdata   = $urandom;
         if ($urandom_range(0, 1) == 0) t.addr[1:0] = 2'b00;
         e = model(t);
         run_txn(t, o);
         compare($sformatf("rand%0d", i), t, e, o);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
